// File: rtl/vga_rect_fill_pkg.sv
// Shared frame-buffer geometry, state encodings and command record for the
// rectangle fill engine.
package vga_rect_fill_pkg;

  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int FB_ADDR_W = 19;
  localparam int FB_DATA_W = 16;
  localparam int COLOR_W   = 12;
  localparam int COORD_W   = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLIP = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [COLOR_W-1:0] color;
  } fill_cmd_t;

endpackage

// File: rtl/vga_rect_walker.sv
// Raster walker: tracks column, row and row base address of the pixel being
// written, and predicts the following address so the write port never idles.
module vga_rect_walker
  import vga_rect_fill_pkg::*;
#(
  parameter int SCREEN_WIDTH = FB_WIDTH,
  parameter int ADDR_W       = FB_ADDR_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               load,
  input  logic               step,
  input  logic               abort,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [ADDR_W-1:0]  base0,
  input  logic [COORD_W:0]   x_end,
  input  logic [COORD_W:0]   y_end,
  output logic [ADDR_W-1:0]  addr,
  output logic [ADDR_W-1:0]  next_addr,
  output logic               last
);

  logic [COORD_W-1:0] cx;
  logic [COORD_W-1:0] cy;
  logic [COORD_W-1:0] x_start;
  logic [ADDR_W-1:0]  row_base;
  logic               col_last;
  logic               row_last;

  assign col_last  = ({1'b0, cx} + (COORD_W+1)'(1)) >= x_end;
  assign row_last  = ({1'b0, cy} + (COORD_W+1)'(1)) >= y_end;
  assign last      = col_last && row_last;
  assign addr      = row_base + ADDR_W'(cx);
  // Wrapping to the next line only adds the stride, keeping the fill loop multiplier-free.
  assign next_addr = col_last ? (row_base + ADDR_W'(SCREEN_WIDTH) + ADDR_W'(x_start))
                              : (addr + ADDR_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cx       <= '0;
      cy       <= '0;
      x_start  <= '0;
      row_base <= '0;
    end else if (load) begin
      cx       <= x0;
      cy       <= y0;
      x_start  <= x0;
      row_base <= base0;
    end else if (step && !abort) begin
      if (!col_last) begin
        cx <= cx + COORD_W'(1);
      end else if (!row_last) begin
        cx       <= x_start;
        cy       <= cy + COORD_W'(1);
        row_base <= row_base + ADDR_W'(SCREEN_WIDTH);
      end
    end
  end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: accepts a command, clips it to the visible frame and
// writes the covered pixels row-major into the frame buffer.
module vga_rect_fill
  import vga_rect_fill_pkg::*;
#(
  parameter int SCREEN_WIDTH  = FB_WIDTH,
  parameter int SCREEN_HEIGHT = FB_HEIGHT,
  parameter int ADDR_W        = FB_ADDR_W,
  parameter int DATA_W        = FB_DATA_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [COORD_W-1:0] cmd_w,
  input  logic [COORD_W-1:0] cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               abort,
  output logic               wr_en,
  input  logic               wr_ready,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               done
);

  function automatic logic [COORD_W:0] clip_end(input logic [COORD_W:0] sum,
                                                input logic [COORD_W:0] limit);
    return (sum > limit) ? limit : sum;
  endfunction

  logic [1:0]        state;
  fill_cmd_t         cmd_q;
  logic [COORD_W:0]  x_end_q;
  logic [COORD_W:0]  y_end_q;
  logic              skip_q;
  logic [COORD_W:0]  x_end_c;
  logic [COORD_W:0]  y_end_c;
  logic              empty_c;
  logic [ADDR_W-1:0] base_c;
  logic [ADDR_W-1:0] walk_addr;
  logic [ADDR_W-1:0] walk_next;
  logic              walk_last;
  logic              walk_load;
  logic              walk_step;

  assign x_end_c = clip_end({1'b0, cmd_q.x} + {1'b0, cmd_q.w}, (COORD_W+1)'(SCREEN_WIDTH));
  assign y_end_c = clip_end({1'b0, cmd_q.y} + {1'b0, cmd_q.h}, (COORD_W+1)'(SCREEN_HEIGHT));
  assign empty_c = (cmd_q.w == '0) || (cmd_q.h == '0) ||
                   ({1'b0, cmd_q.x} >= (COORD_W+1)'(SCREEN_WIDTH)) ||
                   ({1'b0, cmd_q.y} >= (COORD_W+1)'(SCREEN_HEIGHT));
  assign base_c  = ADDR_W'(cmd_q.y) * ADDR_W'(SCREEN_WIDTH);

  assign cmd_ready = (state == ST_IDLE);
  assign walk_load = (state == ST_CLIP);
  assign walk_step = (state == ST_FILL) && wr_en && wr_ready;

  vga_rect_walker #(
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .ADDR_W       (ADDR_W)
  ) u_walker (
    .clk       (clk),
    .rstn      (rstn),
    .load      (walk_load),
    .step      (walk_step),
    .abort     (abort),
    .x0        (cmd_q.x),
    .y0        (cmd_q.y),
    .base0     (base_c),
    .x_end     (x_end_q),
    .y_end     (y_end_q),
    .addr      (walk_addr),
    .next_addr (walk_next),
    .last      (walk_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      cmd_q   <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      skip_q  <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_q <= '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};
            busy  <= 1'b1;
            state <= ST_CLIP;
          end
        end
        ST_CLIP: begin
          x_end_q <= x_end_c;
          y_end_q <= y_end_c;
          skip_q  <= empty_c || abort;
          state   <= ST_FILL;
        end
        ST_FILL: begin
          // First FILL cycle primes the write port from the freshly loaded walker.
          if (!wr_en) begin
            if (skip_q || abort) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= walk_addr;
              wr_data <= {{(DATA_W-COLOR_W){1'b0}}, cmd_q.color};
            end
          end else if (abort || (wr_ready && walk_last)) begin
            wr_en <= 1'b0;
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (wr_ready) begin
            wr_addr <= walk_next;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Bench for vga_rect_fill: directed vector table, corner-case sequences and
// randomized commands checked against a pixel-list model of the clipped fill.
module tb_vga_rect_fill;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [11:0] cmd_color = '0;
  logic        abort = 1'b0;
  logic        wr_en;
  logic        wr_ready = 1'b1;
  logic [18:0] wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  vga_rect_fill dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .abort     (abort),
    .wr_en     (wr_en),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          x, y, w, h;
    logic [11:0] col;
    int          rmode;
    int          abort_hs;
    int          n, first, last;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // rmode: 0 ready always, 1 random ready, 2 ready low for the first 3 write cycles.
  task automatic run_cmd(input int x, input int y, input int w, input int h,
                         input logic [11:0] col, input int rmode, input int abort_hs,
                         input string nm, output int n_wr, output int first_a,
                         output int last_a);
    int exp_q[$];
    int p, start, first_cyc, done_cyc, last_hs, stalls;
    bit holding;
    logic [18:0] held;
    for (int yy = y; yy < y + h && yy < 480; yy++)
      for (int xx = x; xx < x + w && xx < 640; xx++)
        exp_q.push_back(yy * 640 + xx);
    p = (abort_hs > 0 && abort_hs < exp_q.size()) ? abort_hs : exp_q.size();
    n_wr = 0; first_a = -1; last_a = -1; first_cyc = -1; done_cyc = -1;
    last_hs = -1; stalls = 0; holding = 1'b0; held = '0;
    @(negedge clk);
    check({nm, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    cmd_x = 10'(x); cmd_y = 10'(y); cmd_w = 10'(w); cmd_h = 10'(h);
    cmd_color = col; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    start = cyc;
    cmd_valid = 1'b0;
    check({nm, "_busy_rise"}, 64'(busy), 64'd1);
    for (int t = 0; t < 3000 && done_cyc < 0; t++) begin
      @(negedge clk);
      case (rmode)
        1:       wr_ready = 1'($urandom_range(0, 1));
        2:       wr_ready = !(wr_en && stalls < 3);
        default: wr_ready = 1'b1;
      endcase
      if (rmode == 2 && wr_en && !wr_ready) stalls++;
      abort = (abort_hs > 0 && wr_en && wr_ready && n_wr == abort_hs - 1);
      if (wr_en) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (holding) check({nm, "_hold_addr"}, 64'(wr_addr), 64'(held));
        check({nm, "_data"}, 64'(wr_data), 64'({4'h0, col}));
        if (wr_ready) begin
          if (n_wr < exp_q.size()) check({nm, "_addr"}, 64'(wr_addr), 64'(exp_q[n_wr]));
          else check({nm, "_extra_write"}, 64'(wr_addr), 64'hFFFF_FFFF);
          if (n_wr == 0) first_a = int'(wr_addr);
          last_a = int'(wr_addr);
          n_wr++;
          last_hs = cyc;
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          held = wr_addr;
        end
      end
      if (done) begin
        done_cyc = cyc;
        check({nm, "_busy_at_done"}, 64'(busy), 64'd0);
        check({nm, "_ready_at_done"}, 64'(cmd_ready), 64'd0);
      end
    end
    abort = 1'b0;
    wr_ready = 1'b1;
    if (done_cyc < 0) check({nm, "_done_timeout"}, 64'd0, 64'd1);
    check({nm, "_writes"}, 64'(n_wr), 64'(p));
    if (p == 0) check({nm, "_done_cycle"}, 64'(done_cyc - start), 64'd2);
    else begin
      check({nm, "_first_wr_cycle"}, 64'(first_cyc - start), 64'd2);
      check({nm, "_done_after_last"}, 64'(done_cyc), 64'(last_hs + 1));
      if (rmode != 1) check({nm, "_done_latency"}, 64'(done_cyc - start), 64'(2 + p + stalls));
    end
    @(negedge clk);
    check({nm, "_ready_after"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    int n, fa, la, rx, ry, ab, rm;
    int writes, done_cnt, d1, acc_cyc, accepts;
    bit drop;

    vecs[0] = '{2, 1, 3, 2, 12'hF00, 0, 0, 6, 642, 1284};
    vecs[1] = '{638, 478, 10, 10, 12'h0AB, 0, 0, 4, 306558, 307199};
    vecs[2] = '{5, 5, 0, 4, 12'h123, 0, 0, 0, -1, -1};
    vecs[3] = '{640, 10, 5, 5, 12'h456, 0, 0, 0, -1, -1};
    vecs[4] = '{7, 3, 2, 1, 12'h789, 2, 0, 2, 1927, 1928};
    vecs[5] = '{0, 0, 3, 3, 12'hABC, 0, 4, 4, 0, 640};
    vecs[6] = '{0, 0, 640, 1, 12'hFFF, 0, 0, 640, 0, 639};
    vecs[7] = '{639, 479, 1, 1, 12'h00F, 0, 0, 1, 307199, 307199};
    vecs[8] = '{10, 480, 4, 4, 12'h0F0, 0, 0, 0, -1, -1};
    vecs[9] = '{100, 50, 4, 0, 12'h111, 0, 0, 0, -1, -1};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].col, vecs[i].rmode,
              vecs[i].abort_hs, $sformatf("vec%0d", i), n, fa, la);
      check($sformatf("vec%0d_count", i), 64'(n), 64'(vecs[i].n));
      check($sformatf("vec%0d_first", i), 64'(fa), 64'(vecs[i].first));
      check($sformatf("vec%0d_last", i), 64'(la), 64'(vecs[i].last));
    end

    // Command held valid while busy: accepted exactly once, the cycle after done.
    @(negedge clk);
    cmd_x = 10'd0; cmd_y = 10'd0; cmd_w = 10'd3; cmd_h = 10'd2; cmd_color = 12'h321;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_x = 10'd5; cmd_y = 10'd5; cmd_w = 10'd1; cmd_h = 10'd1; cmd_color = 12'h654;
    writes = 0; done_cnt = 0; d1 = -1; acc_cyc = -1; accepts = 0; drop = 1'b0;
    for (int t = 0; t < 200 && done_cnt < 2; t++) begin
      @(negedge clk);
      if (drop) begin cmd_valid = 1'b0; drop = 1'b0; end
      if (wr_en) writes++;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) d1 = cyc;
      end
      if (cmd_valid && cmd_ready) begin
        accepts++;
        acc_cyc = cyc;
        drop = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    check("holdoff_done_pulses", 64'(done_cnt), 64'd2);
    check("holdoff_accepts", 64'(accepts), 64'd1);
    check("holdoff_accept_cycle", 64'(acc_cyc - d1), 64'd1);
    check("holdoff_writes", 64'(writes), 64'd7);
    @(negedge clk);

    // Randomized commands against the pixel-list model
    for (int i = 0; i < 30; i++) begin
      rx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(600, 645)) : int'($urandom_range(0, 639));
      ry = ($urandom_range(0, 2) == 0) ? int'($urandom_range(460, 485)) : int'($urandom_range(0, 479));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      rm = int'($urandom_range(0, 1));
      run_cmd(rx, ry, int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
              12'($urandom), rm, ab, $sformatf("rnd%0d", i), n, fa, la);
    end

    // Reset asserted mid-fill
    @(negedge clk);
    cmd_x = 10'd20; cmd_y = 10'd20; cmd_w = 10'd10; cmd_h = 10'd10; cmd_color = 12'hACE;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_pre_wr_en", 64'(wr_en), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_wr_en", 64'(wr_en), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    rstn = 1'b1;
    writes = 0;
    repeat (20) begin
      @(negedge clk);
      if (wr_en || busy) writes++;
    end
    check("midrst_no_activity", 64'(writes), 64'd0);
    check("midrst_ready_after", 64'(cmd_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
